// File: rtl/psdsqrt_param.sv
// psdsqrt_param: sequential integer square root, one root bit per clock, with remainder and optional rounding
module psdsqrt_param #(
  parameter int NBITS_IN = 32
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic                  round_en_i,
  input  logic [NBITS_IN-1:0]   xin_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [NBITS_IN/2-1:0] sqrt_o,
  output logic [NBITS_IN/2:0]   rem_o,
  output logic                  sat_o
);
  localparam int N  = NBITS_IN / 2;
  localparam int CW = $clog2(N) + 1;
  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;
  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NBITS_IN-1:0]   x_q, x_d;
  logic [N:0]            acc_q, acc_d;
  logic [N-1:0]          root_q, root_d;
  logic                  rnd_q, rnd_d;
  logic                  done_q, done_d;
  logic [N-1:0]          sqrt_q, sqrt_d;
  logic [N:0]            rem_q, rem_d;
  logic                  sat_q, sat_d;
  logic [N+1:0]          acc_sh, trial;
  logic [N:0]            diff;
  logic                  ge, up, ovf;
  // One shift-subtract step: bring in the next operand bit pair and try (4r+1).
  // The remainder before shifting never exceeds 2r < 2^N, so its low N bits suffice;
  // when the trial succeeds the new remainder fits N+1 bits, so a narrow subtract is exact.
  always_comb begin
    acc_sh = {acc_q[N-1:0], x_q[NBITS_IN-1:NBITS_IN-2]};
    trial  = {root_q, 2'b01};
    ge     = acc_sh >= trial;
    diff   = acc_sh[N:0] - trial[N:0];
    up     = rnd_q && ({1'b0, root_q} < acc_q);
    ovf    = up && (&root_q);
  end
  // Next-state and datapath control; abort only matters once an operation is running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_d     = x_q;
    acc_d   = acc_q;
    root_d  = root_q;
    rnd_d   = rnd_q;
    done_d  = 1'b0;
    sqrt_d  = sqrt_q;
    rem_d   = rem_q;
    sat_d   = sat_q;
    case (state_q)
      IDLE: if (start_i) begin
        state_d = CALC;
        x_d     = xin_i;
        rnd_d   = round_en_i;
        acc_d   = '0;
        root_d  = '0;
        cnt_d   = CW'(N - 1);
      end
      CALC: if (abort_i) state_d = IDLE;
      else begin
        x_d     = {x_q[NBITS_IN-3:0], 2'b00};
        acc_d   = ge ? diff : acc_sh[N:0];
        root_d  = {root_q[N-2:0], ge};
        cnt_d   = cnt_q - CW'(1);
        state_d = (cnt_q == '0) ? FIN : CALC;
      end
      FIN: begin
        state_d = IDLE;
        if (!abort_i) begin
          done_d = 1'b1;
          sqrt_d = ovf ? root_q : root_q + {{(N-1){1'b0}}, up};
          rem_d  = acc_q;
          sat_d  = ovf;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  // State and result registers with synchronous active-low reset.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      x_q     <= '0;
      acc_q   <= '0;
      root_q  <= '0;
      rnd_q   <= 1'b0;
      done_q  <= 1'b0;
      sqrt_q  <= '0;
      rem_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      acc_q   <= acc_d;
      root_q  <= root_d;
      rnd_q   <= rnd_d;
      done_q  <= done_d;
      sqrt_q  <= sqrt_d;
      rem_q   <= rem_d;
      sat_q   <= sat_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign done_o = done_q;
  assign sqrt_o = sqrt_q;
  assign rem_o  = rem_q;
  assign sat_o  = sat_q;
endmodule

// File: tb/tb_psdsqrt_param.sv
// tb_psdsqrt_param: directed vectors and handshake sequences for the sequential square root
module tb_psdsqrt_param;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;
  logic        start = 1'b0, abort = 1'b0, rnd = 1'b0;
  logic [31:0] xin = '0;
  logic        busy, done, sat;
  logic [15:0] sq;
  logic [16:0] rm;
  logic        s8 = 1'b0, r8 = 1'b0;
  logic [7:0]  x8 = '0;
  logic        b8, d8, sat8;
  logic [3:0]  sq8;
  logic [4:0]  rm8;
  int tests = 0, fails = 0;
  psdsqrt_param #(.NBITS_IN(32)) dut (
    .clock_i(clock), .reset_i(reset), .start_i(start), .abort_i(abort), .round_en_i(rnd),
    .xin_i(xin), .busy_o(busy), .done_o(done), .sqrt_o(sq), .rem_o(rm), .sat_o(sat)
  );
  psdsqrt_param #(.NBITS_IN(8)) dut8 (
    .clock_i(clock), .reset_i(reset), .start_i(s8), .abort_i(1'b0), .round_en_i(r8),
    .xin_i(x8), .busy_o(b8), .done_o(d8), .sqrt_o(sq8), .rem_o(rm8), .sat_o(sat8)
  );
  typedef struct packed {
    logic [31:0] x;
    logic        r;
    logic [15:0] s;
    logic [16:0] m;
    logic        st;
  } vec_t;
  vec_t v [12];
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  task automatic go(input logic [31:0] x, input logic r);
    xin = x;
    rnd = r;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!done && cyc < 40) begin
      @(negedge clock);
      cyc++;
    end
  endtask
  initial begin
    int cyc, n, first;
    v[0]  = '{32'd123456,     1'b0, 16'd351,    17'd255,    1'b0};
    v[1]  = '{32'd15,         1'b1, 16'd4,      17'd6,      1'b0};
    v[2]  = '{32'd12,         1'b1, 16'd3,      17'd3,      1'b0};
    v[3]  = '{32'd0,          1'b0, 16'd0,      17'd0,      1'b0};
    v[4]  = '{32'd0,          1'b1, 16'd0,      17'd0,      1'b0};
    v[5]  = '{32'hFFFFFFFF,   1'b1, 16'hFFFF,   17'd131070, 1'b1};
    v[6]  = '{32'hFFFFFFFF,   1'b0, 16'hFFFF,   17'd131070, 1'b0};
    v[7]  = '{32'd3,          1'b1, 16'd2,      17'd2,      1'b0};
    v[8]  = '{32'd2,          1'b1, 16'd1,      17'd1,      1'b0};
    v[9]  = '{32'hFFFE0001,   1'b1, 16'hFFFF,   17'd0,      1'b0};
    v[10] = '{32'hFFFF0000,   1'b1, 16'hFFFF,   17'd65535,  1'b0};
    v[11] = '{32'hFFFF0001,   1'b1, 16'hFFFF,   17'd65536,  1'b1};
    repeat (3) @(negedge clock);
    chk("reset busy/done/sat", {busy, done, sat}, 0);
    chk("reset sqrt/rem", {sq, rm}, 0);
    reset = 1'b1;
    @(negedge clock);
    for (int i = 0; i < 12; i++) begin
      go(v[i].x, v[i].r);
      chk($sformatf("vec%0d busy", i), busy, 1);
      wait_done(cyc);
      chk($sformatf("vec%0d latency", i), cyc, 17);
      chk($sformatf("vec%0d busy at done", i), busy, 0);
      chk($sformatf("vec%0d sqrt", i), sq, v[i].s);
      chk($sformatf("vec%0d rem", i), rm, v[i].m);
      chk($sformatf("vec%0d sat", i), sat, v[i].st);
      @(negedge clock);
      chk($sformatf("vec%0d done pulse", i), done, 0);
    end
    go(32'd123456, 1'b0);
    n = 0;
    first = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == 5) begin
        xin = 32'd999;
        start = 1'b1;
      end else start = 1'b0;
      @(negedge clock);
      if (done) begin
        n++;
        if (first == 0) first = c;
      end
    end
    chk("busy start done count", n, 1);
    chk("busy start done cycle", first, 17);
    chk("busy start sqrt", sq, 351);
    go(32'd15, 1'b1);
    wait_done(cyc);
    chk("b2b first sqrt/rem", {sq, rm}, {16'd4, 17'd6});
    go(32'd12, 1'b1);
    wait_done(cyc);
    chk("b2b second latency", cyc, 17);
    chk("b2b second sqrt/rem", {sq, rm}, {16'd3, 17'd3});
    go(32'd123456, 1'b0);
    repeat (7) @(negedge clock);
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("abort busy", busy, 0);
    n = 0;
    repeat (30) begin
      @(negedge clock);
      if (done) n++;
    end
    chk("abort no done", n, 0);
    chk("abort outputs held", {sq, rm, sat}, {16'd3, 17'd3, 1'b0});
    abort = 1'b1;
    go(32'd65536, 1'b0);
    abort = 1'b0;
    wait_done(cyc);
    chk("start beats abort latency", cyc, 17);
    chk("start beats abort result", {sq, rm}, {16'd256, 17'd0});
    go(32'hFFFFFFFF, 1'b1);
    wait_done(cyc);
    chk("pre-reset sat", sat, 1);
    go(32'hFFFFFFFF, 1'b1);
    repeat (5) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    chk("midreset busy/done/sat", {busy, done, sat}, 0);
    chk("midreset sqrt/rem", {sq, rm}, 0);
    reset = 1'b1;
    go(32'd123456, 1'b0);
    wait_done(cyc);
    chk("post-reset latency", cyc, 17);
    chk("post-reset result", {sq, rm, sat}, {16'd351, 17'd255, 1'b0});
    for (int x = 0; x < 256; x++) begin
      for (int r = 0; r < 2; r++) begin
        int g, gr, gs, gsat;
        x8 = 8'(x);
        r8 = r[0];
        s8 = 1'b1;
        @(negedge clock);
        s8 = 1'b0;
        cyc = 0;
        while (!d8 && cyc < 20) begin
          @(negedge clock);
          cyc++;
        end
        g = 0;
        while ((g + 1) * (g + 1) <= x) g++;
        gr = x - g * g;
        gs = g;
        gsat = 0;
        if (r == 1 && gr > g) begin
          if (g == 15) gsat = 1;
          else gs = g + 1;
        end
        chk($sformatf("n8 x=%0d r=%0d {lat,sqrt,rem,sat}", x, r), {8'(cyc), sq8, rm8, sat8},
            {8'd5, 4'(gs), 5'(gr), gsat[0]});
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
